// File: rtl/viterbi_pkg.sv
// Shared types and constants for the encoder -> channel -> Viterbi link test controller.
// Holds the run-phase states, PRBS16 seed and taps, counter width and saturating helpers.
package viterbi_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [15:0] PRBS_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 in right-shift Fibonacci form: feedback from bits 0, 2, 3, 5
    localparam logic [15:0] PRBS_TAPS = 16'h002D;

    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return 2'(m[0]) + 2'(m[1]);
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/prbs16.sv
// PRBS16 source (x^16+x^14+x^13+x^11+1), loadable to its seed and stepped on demand.
// o_out is bit 0 of the current state, so the first bit after a load is SEED[0].
module prbs16
    import viterbi_pkg::*;
#(
    parameter logic [15:0] SEED = PRBS_SEED
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_step,
    output logic o_out
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb  = ^(r_lfsr & PRBS_TAPS);
    assign o_out = r_lfsr[0];

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_lfsr <= SEED;
        end else if (i_step) begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

endmodule

// File: rtl/viterbi_link_ctrl.sv
// Test-run controller for the encoder -> channel -> Viterbi decoder link: sequences data,
// trellis-flush tail and decoder drain, injects channel errors and scores decoded bits.
module viterbi_link_ctrl
    import viterbi_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned WORDS   = 256,
    parameter int unsigned FLUSH   = 8,
    parameter int unsigned DEC_LAT = 32,
    parameter logic [15:0] SEED    = PRBS_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        err_en,
    input  logic [1:0]  err_mask,
    input  logic        decoder_o_i,
    output logic        encoder_i,
    output logic        enable_enc_o,
    output logic [1:0]  err_inj_o,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] inj_ct,
    output logic [15:0] bit_err_ct
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_word_ct;
    logic [CNT_W-1:0]   r_ph_ct;
    logic               r_err_en;
    logic [1:0]         r_err_mask;
    logic               r_inj_pend;
    logic               r_tag;
    logic [1:0]         r_dly [DEC_LAT];

    logic               w_prbs_load;
    logic               w_prbs_step;
    logic               w_prbs_out;
    logic               w_dly_bit;
    logic               w_dly_tag;
    logic               w_mismatch;
    logic               w_inj_hit;

    assign w_prbs_load = (r_state == S_IDLE) && start;
    assign w_prbs_step = (r_state == S_RUN);

    prbs16 #(
        .SEED (SEED)
    ) u_prbs (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_prbs_load),
        .i_step (w_prbs_step),
        .o_out  (w_prbs_out)
    );

    // Oldest delay-line entry lines up with the decoder output for the same encoder bit
    assign w_dly_bit  = r_dly[DEC_LAT-1][1];
    assign w_dly_tag  = r_dly[DEC_LAT-1][0];
    assign w_mismatch = w_dly_tag && (decoder_o_i != w_dly_bit);
    assign w_inj_hit  = r_err_en && (&r_word_ct[N-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_word_ct    <= '0;
            r_ph_ct      <= '0;
            r_err_en     <= 1'b0;
            r_err_mask   <= 2'b00;
            r_inj_pend   <= 1'b0;
            r_tag        <= 1'b0;
            encoder_i    <= 1'b0;
            enable_enc_o <= 1'b0;
            err_inj_o    <= 2'b00;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            inj_ct       <= '0;
            bit_err_ct   <= '0;
            for (int i = 0; i < int'(DEC_LAT); i++) begin
                r_dly[i] <= 2'b00;
            end
        end else begin
            done       <= 1'b0;
            err_inj_o  <= r_inj_pend ? r_err_mask : 2'b00;
            r_inj_pend <= 1'b0;

            r_dly[0] <= {encoder_i, r_tag};
            for (int i = int'(DEC_LAT) - 1; i > 0; i--) begin
                r_dly[i] <= r_dly[i-1];
            end

            if (w_mismatch) begin
                bit_err_ct <= sat_add(bit_err_ct, 2'd1);
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        r_word_ct  <= '0;
                        inj_ct     <= '0;
                        bit_err_ct <= '0;
                        r_err_en   <= err_en;
                        r_err_mask <= err_mask;
                    end
                end
                S_RUN: begin
                    enable_enc_o <= 1'b1;
                    encoder_i    <= w_prbs_out;
                    r_tag        <= 1'b1;
                    r_word_ct    <= r_word_ct + CNT_W'(1);
                    // The flip lands one cycle later, on the encoder output of this word
                    if (w_inj_hit) begin
                        r_inj_pend <= 1'b1;
                        inj_ct     <= sat_add(inj_ct, popcount2(r_err_mask));
                    end
                    if (r_word_ct == CNT_W'(WORDS - 1)) begin
                        r_state <= S_FLUSH;
                        r_ph_ct <= '0;
                    end
                end
                S_FLUSH: begin
                    enable_enc_o <= 1'b1;
                    encoder_i    <= 1'b0;
                    r_tag        <= 1'b0;
                    r_ph_ct      <= r_ph_ct + CNT_W'(1);
                    if (r_ph_ct == CNT_W'(FLUSH - 1)) begin
                        r_state <= S_DRAIN;
                        r_ph_ct <= '0;
                    end
                end
                S_DRAIN: begin
                    enable_enc_o <= 1'b0;
                    encoder_i    <= 1'b0;
                    r_tag        <= 1'b0;
                    r_ph_ct      <= r_ph_ct + CNT_W'(1);
                    // A last-word comparison may still be landing on this edge
                    if (r_ph_ct == CNT_W'(DEC_LAT - 1)) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        pass    <= (bit_err_ct == '0) && !w_mismatch;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
